traffic_phase_scheduler: RTL and testbench

Round-robin traffic-light phase controller that consumes the per-road averaged vehicle counts produced by the four direction sensors and drives the `next_road` select those sensors sample on. It cycles each road through ALL_RED → GREEN → YELLOW. Green time is the road's current average count, clamped to configured limits. It sits above the sensor unit and is the sole source of `next_road` and the lamp outputs.

---
 rtl/traffic_phase_scheduler.sv | 141 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//
// Round-robin traffic-light phase controller. Each road in turn is taken
// through ALL_RED -> GREEN -> YELLOW. The green length is the road's averaged
// vehicle count, clamped to [MIN_GREEN, MAX_GREEN]. That count is sampled once,
// at the ALL_RED->GREEN edge. This block is the only source of next_road, which
// the direction sensors use to pick the road they refresh.
//
// Optional build macro:
//   SKIP_EMPTY_EN - a road whose average is 0 at the decision edge gets no
//                   green or yellow. The controller moves straight to the next
//                   road's ALL_RED.
//
// Parameters:
//   MIN_GREEN    (5)  minimum green duration in cycles, >= 1
//   MAX_GREEN    (60) maximum green duration in cycles, MIN_GREEN..255
//   YELLOW_TIME  (3)  yellow duration in cycles, >= 1
//   ALL_RED_TIME (1)  all-red clearance duration in cycles, >= 1
//
// Ports:
//   clk                                   in   rising-edge clock
//   reset                                 in   synchronous, active-high reset
//   avg_north/avg_east/avg_south/avg_west in  8 sensor averages, roads 0..3
//   next_road                             out 2 road being or about to be served
//   green                                 out 4 one-hot green lamp, zero outside GREEN
//   yellow                                out 4 one-hot yellow lamp, zero outside YELLOW
//   timer                                 out 8 cycles left in current phase, minus one
//   phase                                 out 2 0 = ALL_RED, 1 = GREEN, 2 = YELLOW
module traffic_phase_scheduler #(
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 60,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] avg_north,
  input  logic [7:0] avg_east,
  input  logic [7:0] avg_south,
  input  logic [7:0] avg_west,
  output logic [1:0] next_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [7:0] timer,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_t;

  localparam logic [7:0] MIN_G        = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G        = 8'(MAX_GREEN);
  localparam logic [7:0] YELLOW_LOAD  = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALL_RED_LOAD = 8'(ALL_RED_TIME - 1);

  phase_t     phase_q;
  logic [7:0] avg_sel;
  logic [7:0] glen;
  logic [3:0] road_onehot;

  // The clamp is applied before the minus-one load, so glen-1 never underflows.
  function automatic logic [7:0] clamp_green(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    if (a < MIN_G) r = MIN_G;
    if (a > MAX_G) r = MAX_G;
    return r;
  endfunction

  // next_road doubles as the current-road register.
  always_comb begin
    avg_sel = avg_north;
    case (next_road)
      2'd0: avg_sel = avg_north;
      2'd1: avg_sel = avg_east;
      2'd2: avg_sel = avg_south;
      2'd3: avg_sel = avg_west;
      default: avg_sel = avg_north;
    endcase
  end

  assign glen        = clamp_green(avg_sel);
  assign road_onehot = 4'b0001 << next_road;
  assign phase       = phase_q;

  // Phase sequencer: one state change per timer expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_ALL_RED;
      next_road <= 2'd0;
      green     <= 4'b0000;
      yellow    <= 4'b0000;
      timer     <= ALL_RED_LOAD;
    end else if (timer != 8'd0) begin
      timer <= timer - 8'd1;
    end else begin
      case (phase_q)
        PH_ALL_RED: begin
`ifdef SKIP_EMPTY_EN
          if (avg_sel == 8'd0) begin
            // Empty road: the controller still visits it, so its sensor keeps
            // refreshing, but the road gets no lamp.
            next_road <= next_road + 2'd1;
            timer     <= ALL_RED_LOAD;
          end else begin
            phase_q <= PH_GREEN;
            green   <= road_onehot;
            timer   <= glen - 8'd1;
          end
`else
          phase_q <= PH_GREEN;
          green   <= road_onehot;
          timer   <= glen - 8'd1;
`endif
        end
        PH_GREEN: begin
          phase_q <= PH_YELLOW;
          green   <= 4'b0000;
          yellow  <= road_onehot;
          timer   <= YELLOW_LOAD;
        end
        PH_YELLOW: begin
          phase_q   <= PH_ALL_RED;
          yellow    <= 4'b0000;
          next_road <= next_road + 2'd1;
          timer     <= ALL_RED_LOAD;
        end
        default: begin
          phase_q <= PH_ALL_RED;
          green   <= 4'b0000;
          yellow  <= 4'b0000;
          timer   <= ALL_RED_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler.
// The stimulus pushes the expected phase segments (road, phase, lamps, length)
// into a queue. A monitor folds the DUT outputs into segments and compares
// each completed segment against the front of that queue.
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN    = 5;
  localparam int MAX_GREEN    = 60;
  localparam int YELLOW_TIME  = 3;
  localparam int ALL_RED_TIME = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] avg_north, avg_east, avg_south, avg_west;
  logic [1:0] next_road;
  logic [3:0] green, yellow;
  logic [7:0] timer;
  logic [1:0] phase;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int seg_idx = 0;

  typedef struct packed {
    logic [1:0] road;
    logic [1:0] ph;
    logic [3:0] g;
    logic [3:0] y;
  } tup_t;

  typedef struct packed {
    tup_t       t;
    logic [7:0] len;
  } seg_t;

  seg_t exp_q[$];

  traffic_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN),
    .YELLOW_TIME(YELLOW_TIME),
    .ALL_RED_TIME(ALL_RED_TIME)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avg_north(avg_north),
    .avg_east(avg_east),
    .avg_south(avg_south),
    .avg_west(avg_west),
    .next_road(next_road),
    .green(green),
    .yellow(yellow),
    .timer(timer),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic push_seg(input logic [1:0] road, input logic [1:0] ph, input int len);
    seg_t s;
    logic [3:0] oh;
    oh = 4'b0001;
    oh = oh << road;
    s.t.road = road;
    s.t.ph   = ph;
    s.t.g    = (ph == 2'd1) ? oh : 4'b0000;
    s.t.y    = (ph == 2'd2) ? oh : 4'b0000;
    s.len    = 8'(len);
    exp_q.push_back(s);
  endtask

  task automatic push_road(input logic [1:0] road, input int glen);
    push_seg(road, 2'd0, ALL_RED_TIME);
    push_seg(road, 2'd1, glen);
    push_seg(road, 2'd2, YELLOW_TIME);
  endtask

  task automatic check_seg(input tup_t t, input int len, input logic [7:0] first_t);
    seg_t e;
    seg_idx++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL seg%0d_unexpected got road=%0d phase=%0d len=%0d, none required",
               seg_idx, t.road, t.ph, len);
      return;
    end
    e = exp_q.pop_front();
    if (t != e.t) begin
      failures++;
      $display("FAIL seg%0d_state got road=%0d phase=%0d green=%b yellow=%b required road=%0d phase=%0d green=%b yellow=%b",
               seg_idx, t.road, t.ph, t.g, t.y, e.t.road, e.t.ph, e.t.g, e.t.y);
    end
    checks++;
    if (len != int'(e.len)) begin
      failures++;
      $display("FAIL seg%0d_len road=%0d phase=%0d got %0d cycles required %0d",
               seg_idx, t.road, t.ph, len, e.len);
    end
    checks++;
    if (first_t != 8'(e.len - 8'd1)) begin
      failures++;
      $display("FAIL seg%0d_timer_load got %0d required %0d", seg_idx, first_t, e.len - 8'd1);
    end
  endtask

  // Monitor: one sample per cycle, between clock edges
  initial begin : monitor
    tup_t       prev, cur;
    int         len;
    logic [7:0] first_t, last_t;
    bit         have;
    have = 1'b0;
    len = 0;
    prev = '0;
    first_t = '0;
    last_t = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        have = 1'b0;
      end else begin
        cur.road = next_road;
        cur.ph   = phase;
        cur.g    = green;
        cur.y    = yellow;
        checks++;
        if ((green != 4'b0 && yellow != 4'b0) || $countones({green, yellow}) > 1) begin
          failures++;
          $display("FAIL lamp_invariant got green=%b yellow=%b required at most one lamp bit",
                   green, yellow);
        end
        if (have && cur == prev) begin
          len++;
          checks++;
          if (timer != 8'(last_t - 8'd1)) begin
            failures++;
            $display("FAIL timer_step got %0d required %0d", timer, 8'(last_t - 8'd1));
          end
          last_t = timer;
        end else begin
          if (have) check_seg(prev, len, first_t);
          prev = cur;
          len = 1;
          first_t = timer;
          last_t = timer;
          have = 1'b1;
        end
      end
    end
  end

  task automatic wait_lamp(input logic [3:0] g, input logic [3:0] y, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(green == g && yellow == y) && n < 400);
    checks++;
    if (!(green == g && yellow == y)) begin
      failures++;
      $display("FAIL wait_%s timed out got green=%b yellow=%b required green=%b yellow=%b",
               name, green, yellow, g, y);
    end
  endtask

  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (phase != 2'd0) begin
      failures++;
      $display("FAIL %s_phase got %0d required 0", tag, phase);
    end
    checks++;
    if (next_road != 2'd0) begin
      failures++;
      $display("FAIL %s_next_road got %0d required 0", tag, next_road);
    end
    checks++;
    if (green != 4'b0) begin
      failures++;
      $display("FAIL %s_green got %b required 0000", tag, green);
    end
    checks++;
    if (yellow != 4'b0) begin
      failures++;
      $display("FAIL %s_yellow got %b required 0000", tag, yellow);
    end
    checks++;
    if (timer != 8'(ALL_RED_TIME - 1)) begin
      failures++;
      $display("FAIL %s_timer got %0d required %0d", tag, timer, ALL_RED_TIME - 1);
    end
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_queue_empty(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got %0d segments left required 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin : stimulus
    avg_north = 8'd20;
    avg_east  = 8'd2;
    avg_south = 8'd200;
    avg_west  = 8'd60;

    // Round 1: clamps (2 -> 5, 200 -> 60, 60 -> 60) and the wrap back to north.
    push_road(2'd0, 20);
    push_road(2'd1, 5);
    push_road(2'd2, 60);
    push_road(2'd3, 60);
    // Round 2: north's average rises mid-green; the green already running stays 20.
    push_road(2'd0, 20);
    push_road(2'd1, 5);
    push_road(2'd2, 60);
    push_road(2'd3, 60);
    // Round 3: north now uses the new average (100 -> 60); south is cut by reset in yellow.
    push_road(2'd0, 60);
    push_road(2'd1, 5);
    push_seg(2'd2, 2'd0, ALL_RED_TIME);
    push_seg(2'd2, 2'd1, 60);

    do_reset("reset1");
    wait_lamp(4'b0001, 4'b0000, "n1");
    wait_lamp(4'b0010, 4'b0000, "e1");
    wait_lamp(4'b0001, 4'b0000, "n2");
    repeat (5) @(negedge clk);
    avg_north = 8'd100;
    wait_lamp(4'b0010, 4'b0000, "e2");
    wait_lamp(4'b0001, 4'b0000, "n3");
    wait_lamp(4'b0000, 4'b0100, "s3y");
    #2;
    check_queue_empty("leg1");

    // Reset during south's yellow, then a short run with an empty east road.
    avg_north = 8'd10;
    avg_east  = 8'd0;
    avg_south = 8'd10;
    avg_west  = 8'd10;
    push_road(2'd0, 10);
`ifdef SKIP_EMPTY_EN
    push_seg(2'd1, 2'd0, ALL_RED_TIME);
`else
    push_road(2'd1, MIN_GREEN);
`endif
    push_seg(2'd2, 2'd0, ALL_RED_TIME);
    push_seg(2'd2, 2'd1, 10);

    do_reset("reset2");
    wait_lamp(4'b0000, 4'b0100, "s4y");
    #2;
    mon_en = 1'b0;
    check_queue_empty("leg2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
